// File: rtl/dip_led_shift_driver.sv
// dip_led_shift_driver
// Serial transmitter for a 74HC595-style shift/storage register chain.
// A WIDTH-bit word accepted over valid/ready is shifted out on sdata/sclk,
// then a latch pulse moves it to the chain's parallel outputs.
// Bit order (BYTE_SWAP=1): upper half LSB-first, then lower half LSB-first.
// Optional feature: define DIP_LED_REFRESH_EN to resend the held word
// automatically after REFRESH_GAP idle cycles.
module dip_led_shift_driver #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned BYTE_SWAP   = 1,
  parameter int unsigned REFRESH_GAP = 1000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sdata,
  output logic             sclk,
  output logic             latch,
  output logic             busy
);

  localparam int unsigned BW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned DW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int unsigned HALF = WIDTH / 2;

  // Reject configurations the bit ordering and divider cannot support.
  if (CLK_DIV < 1 || REFRESH_GAP < 1 || (BYTE_SWAP != 0 && (WIDTH % 8) != 0)) begin : g_bad_param
    $error("dip_led_shift_driver: unsupported parameter combination");
  end

  typedef enum logic [1:0] {IDLE, SHIFT_LO, SHIFT_HI, LATCH} state_t;

  state_t           state;
  logic [WIDTH-1:0] held;      // word being (or last) sent
  logic [BW-1:0]    bit_cnt;   // position in send order, 0..WIDTH-1
  logic [DW-1:0]    div_cnt;   // cycles spent in current phase, 0..CLK_DIV-1

`ifdef DIP_LED_REFRESH_EN
  localparam int unsigned GW = $clog2(REFRESH_GAP + 1);
  logic [GW-1:0] gap_cnt;
`endif

  // Map send position to the word bit that goes out at that position.
  function automatic logic [BW-1:0] send_index(input logic [BW-1:0] b);
    int unsigned bi;
    bi = 32'(b);
    if (BYTE_SWAP != 0) begin
      bi = (bi < HALF) ? bi + HALF : bi - HALF;
    end
    return BW'(bi);
  endfunction

  wire div_last = (div_cnt == DW'(CLK_DIV - 1));

  // Transfer FSM; every output is a register updated alongside the state.
  // NOTE: all state and outputs use non-blocking assignments so every
  // register samples pre-edge values; later assignments in a branch override
  // earlier defaults within the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      held      <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      din_ready <= 1'b0;
      sdata     <= 1'b0;
      sclk      <= 1'b0;
      latch     <= 1'b0;
      busy      <= 1'b0;
`ifdef DIP_LED_REFRESH_EN
      gap_cnt   <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          din_ready <= 1'b1;
          busy      <= 1'b0;
          sclk      <= 1'b0;
          latch     <= 1'b0;
          sdata     <= 1'b0;
          if (din_valid && din_ready) begin
            held      <= din;
            sdata     <= din[send_index('0)];
            state     <= SHIFT_LO;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            din_ready <= 1'b0;
            busy      <= 1'b1;
`ifdef DIP_LED_REFRESH_EN
            gap_cnt   <= '0;
          end else if (gap_cnt == GW'(REFRESH_GAP - 1)) begin
            sdata     <= held[send_index('0)];
            state     <= SHIFT_LO;
            bit_cnt   <= '0;
            div_cnt   <= '0;
            din_ready <= 1'b0;
            busy      <= 1'b1;
            gap_cnt   <= '0;
          end else begin
            gap_cnt   <= gap_cnt + 1'b1;
`endif
          end
        end

        SHIFT_LO: begin
          if (div_last) begin
            div_cnt <= '0;
            sclk    <= 1'b1;
            state   <= SHIFT_HI;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        SHIFT_HI: begin
          if (div_last) begin
            div_cnt <= '0;
            sclk    <= 1'b0;
            if (bit_cnt == BW'(WIDTH - 1)) begin
              latch <= 1'b1;
              state <= LATCH;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              sdata   <= held[send_index(bit_cnt + 1'b1)];
              state   <= SHIFT_LO;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        LATCH: begin
          if (div_last) begin
            div_cnt   <= '0;
            latch     <= 1'b0;
            sdata     <= 1'b0;
            din_ready <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dip_led_shift_driver.sv
// tb_dip_led_shift_driver
// Directed bench: instance A uses WIDTH=16, CLK_DIV=2, BYTE_SWAP=1;
// instance B uses WIDTH=16, CLK_DIV=1, BYTE_SWAP=0. Built without
// DIP_LED_REFRESH_EN, so the block must stay idle between handshakes.
module tb_dip_led_shift_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] din_a, din_b;
  logic        valid_a, valid_b;
  logic        rdy_a, sdata_a, sclk_a, latch_a, busy_a;
  logic        rdy_b, sdata_b, sclk_b, latch_b, busy_b;

  dip_led_shift_driver #(.WIDTH(16), .CLK_DIV(2), .BYTE_SWAP(1), .REFRESH_GAP(10)) dut_a (
    .clk(clk), .rst(rst), .din(din_a), .din_valid(valid_a), .din_ready(rdy_a),
    .sdata(sdata_a), .sclk(sclk_a), .latch(latch_a), .busy(busy_a)
  );

  dip_led_shift_driver #(.WIDTH(16), .CLK_DIV(1), .BYTE_SWAP(0), .REFRESH_GAP(10)) dut_b (
    .clk(clk), .rst(rst), .din(din_b), .din_valid(valid_b), .din_ready(rdy_b),
    .sdata(sdata_b), .sclk(sclk_b), .latch(latch_b), .busy(busy_b)
  );

  // Chain-side monitors, sampled on the falling edge: sdata at each sclk
  // rise, latch pulse count and total latch-high cycles.
  logic bits_a [0:1023];
  logic bits_b [0:1023];
  int   rise_a = 0, lpulse_a = 0, lhigh_a = 0;
  int   rise_b = 0, lpulse_b = 0, lhigh_b = 0;
  logic sclk_q_a = 1'b0, latch_q_a = 1'b0;
  logic sclk_q_b = 1'b0, latch_q_b = 1'b0;

  always @(negedge clk) begin
    if (sclk_a === 1'b1 && sclk_q_a !== 1'b1) begin
      bits_a[rise_a[9:0]] <= sdata_a;
      rise_a <= rise_a + 1;
    end
    if (latch_a === 1'b1 && latch_q_a !== 1'b1) lpulse_a <= lpulse_a + 1;
    if (latch_a === 1'b1) lhigh_a <= lhigh_a + 1;
    sclk_q_a  <= sclk_a;
    latch_q_a <= latch_a;
  end

  always @(negedge clk) begin
    if (sclk_b === 1'b1 && sclk_q_b !== 1'b1) begin
      bits_b[rise_b[9:0]] <= sdata_b;
      rise_b <= rise_b + 1;
    end
    if (latch_b === 1'b1 && latch_q_b !== 1'b1) lpulse_b <= lpulse_b + 1;
    if (latch_b === 1'b1) lhigh_b <= lhigh_b + 1;
    sclk_q_b  <= sclk_b;
    latch_q_b <= latch_b;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Gather 16 recorded bits starting at index s, first-sent bit in [15].
  function automatic logic [15:0] frame_bits(input bit sel, input int s);
    logic [15:0] f;
    for (int i = 0; i < 16; i++) begin
      f[15-i] = sel ? bits_b[s+i] : bits_a[s+i];
    end
    return f;
  endfunction

  // One complete transfer. exp_bits lists the sent order left to right.
  // inject_at >= 0 pulses din_valid with 16'hFFFF on A at that busy cycle.
  task automatic xfer(input string tag, input bit sel, input logic [15:0] word,
                      input logic [15:0] exp_bits, input int exp_lat,
                      input int exp_latch_len, input int inject_at);
    int r0, p0, h0, n;
    r0 = sel ? rise_b : rise_a;
    p0 = sel ? lpulse_b : lpulse_a;
    h0 = sel ? lhigh_b : lhigh_a;
    check($sformatf("%s ready_before", tag), 32'(sel ? rdy_b : rdy_a), 32'd1);
    if (sel) begin din_b = word; valid_b = 1'b1; end
    else     begin din_a = word; valid_a = 1'b1; end
    tick();
    valid_a = 1'b0;
    valid_b = 1'b0;
    din_a = ~word;
    din_b = ~word;
    n = 0;
    while (!(sel ? rdy_b : rdy_a) && n < 400) begin
      if (n == inject_at) begin
        din_a   = 16'hFFFF;
        valid_a = 1'b1;
      end
      tick();
      n++;
      valid_a = 1'b0;
    end
    check($sformatf("%s latency", tag), 32'(n), 32'(exp_lat));
    check($sformatf("%s sclk_rises", tag), 32'((sel ? rise_b : rise_a) - r0), 32'd16);
    check($sformatf("%s latch_pulses", tag), 32'((sel ? lpulse_b : lpulse_a) - p0), 32'd1);
    check($sformatf("%s latch_len", tag), 32'((sel ? lhigh_b : lhigh_a) - h0), 32'(exp_latch_len));
    check($sformatf("%s bits", tag), 32'(frame_bits(sel, r0)), 32'(exp_bits));
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int r0, p0, n;
    rst = 1'b1;
    din_a = '0; din_b = '0;
    valid_a = 1'b0; valid_b = 1'b0;

    // 1. reset: all outputs low while rst is high, ready one cycle after release
    tick();
    valid_a = 1'b1;  // handshake attempts during reset must be ignored
    din_a   = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      check("reset outputs a", 32'({rdy_a, sdata_a, sclk_a, latch_a, busy_a}), 32'd0);
      check("reset outputs b", 32'({rdy_b, sdata_b, sclk_b, latch_b, busy_b}), 32'd0);
      tick();
    end
    valid_a = 1'b0;
    rst = 1'b0;
    check("ready before first edge", 32'(rdy_a), 32'd0);
    tick();
    check("ready after release a", 32'({rdy_a, busy_a}), 32'b10);
    check("ready after release b", 32'({rdy_b, busy_b}), 32'b10);
    check("no rises during reset", 32'(rise_a + lpulse_a), 32'd0);

    // 2. basic frame
    xfer("a55a", 1'b0, 16'hA55A, 16'b1010_0101_0101_1010, 66, 2, -1);

    // 3. din_valid while busy is ignored
    xfer("busy_ignore", 1'b0, 16'h0001, 16'b0000_0000_1000_0000, 66, 2, 10);

    // 4. reset after the 5th sclk rise aborts without a latch pulse
    p0 = lpulse_a;
    din_a = 16'hA55A; valid_a = 1'b1;
    tick();
    valid_a = 1'b0;
    r0 = rise_a;
    n = 0;
    while ((rise_a - r0) < 5 && n < 200) begin
      tick();
      n++;
    end
    check("abort reached 5 rises", 32'(rise_a - r0), 32'd5);
    rst = 1'b1;
    tick();
    check("abort outputs", 32'({rdy_a, sdata_a, sclk_a, latch_a, busy_a}), 32'd0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) tick();
    check("abort no latch", 32'(lpulse_a - p0), 32'd0);
    xfer("after_abort", 1'b0, 16'h1234, 16'b0100_1000_0010_1100, 66, 2, -1);

    // 5. din_valid held high: back-to-back frames one idle cycle apart
    r0 = rise_a;
    p0 = lpulse_a;
    din_a = 16'h00FF; valid_a = 1'b1;
    tick();
    din_a = 16'hFF00;
    n = 0;
    while (!rdy_a && n < 400) begin tick(); n++; end
    check("b2b first latency", 32'(n), 32'd66);
    tick();
    check("b2b single idle cycle", 32'(rdy_a), 32'd0);
    valid_a = 1'b0;
    n = 0;
    while (!rdy_a && n < 400) begin tick(); n++; end
    check("b2b second latency", 32'(n), 32'd66);
    check("b2b rises", 32'(rise_a - r0), 32'd32);
    check("b2b latches", 32'(lpulse_a - p0), 32'd2);
    check("b2b frame1", 32'(frame_bits(1'b0, r0)), 32'(16'b0000_0000_1111_1111));
    check("b2b frame2", 32'(frame_bits(1'b0, r0 + 16)), 32'(16'b1111_1111_0000_0000));

    // 6. BYTE_SWAP=0, CLK_DIV=1 instance
    xfer("b_8001", 1'b1, 16'h8001, 16'b1000_0000_0000_0001, 33, 1, -1);

    // without the refresh option the outputs stay static while idle
    r0 = rise_a;
    for (int i = 0; i < 20; i++) tick();
    check("idle static rises", 32'(rise_a - r0), 32'd0);
    check("idle static outputs", 32'({rdy_a, sdata_a, sclk_a, latch_a, busy_a}), 32'b10000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
